// File: rtl/axi3_rw_arbiter_if.sv
// AXI3 channel bundle used for both upstream cache ports and the downstream port.
// The master modport drives AR/AW/W and the R/B readies; the slave modport drives the rest.
interface axi3_rw_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [3:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [1:0]          arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [3:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [1:0]          awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [ID_W-1:0]     wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi3_rw_arbiter.sv
// Two-master (dcache = port 0, icache = port 1) to one-slave AXI3 arbiter with independent
// round-robin read and write arbiters, one outstanding transaction per direction.
module axi3_rw_arbiter (
    input  logic              i_clk,
    input  logic              i_rst,
    axi3_rw_arbiter_if.slave  s0,
    axi3_rw_arbiter_if.slave  s1,
    axi3_rw_arbiter_if.master m,
    output logic [1:0]        o_rd_owner,
    output logic [1:0]        o_wr_owner
);
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ADDR = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_ADDR = 2'd1;
    localparam logic [1:0] W_DATA = 2'd2;
    localparam logic [1:0] W_RESP = 2'd3;

    logic [1:0] r_rd_state;
    logic [1:0] r_rd_owner;
    logic       r_rd_last;
    logic [1:0] r_wr_state;
    logic [1:0] r_wr_owner;
    logic       r_wr_last;

    logic w_rd_gnt1, w_rd_sel, w_rd_addr, w_rd_data;
    logic w_wr_gnt1, w_wr_sel, w_wr_addr, w_wr_data, w_wr_resp;

    // r_*_last holds the previous winner, so on contention the other port wins.
    assign w_rd_gnt1 = s1.arvalid & (~s0.arvalid | ~r_rd_last);
    assign w_wr_gnt1 = s1.awvalid & (~s0.awvalid | ~r_wr_last);

    assign w_rd_sel  = r_rd_owner[1];
    assign w_rd_addr = (r_rd_state == R_ADDR);
    assign w_rd_data = (r_rd_state == R_DATA);
    assign w_wr_sel  = r_wr_owner[1];
    assign w_wr_addr = (r_wr_state == W_ADDR);
    assign w_wr_data = (r_wr_state == W_DATA);
    assign w_wr_resp = (r_wr_state == W_RESP);

    // Read arbiter FSM
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_state <= R_IDLE;
            r_rd_owner <= 2'b00;
            r_rd_last  <= 1'b1;
        end else begin
            case (r_rd_state)
                R_IDLE: if (s0.arvalid | s1.arvalid) begin
                    r_rd_owner <= w_rd_gnt1 ? 2'b10 : 2'b01;
                    r_rd_last  <= w_rd_gnt1;
                    r_rd_state <= R_ADDR;
                end
                R_ADDR: if (m.arvalid & m.arready) r_rd_state <= R_DATA;
                R_DATA: if (m.rvalid & m.rready & m.rlast) begin
                    r_rd_state <= R_IDLE;
                    r_rd_owner <= 2'b00;
                end
                default: begin
                    r_rd_state <= R_IDLE;
                    r_rd_owner <= 2'b00;
                end
            endcase
        end
    end

    // Write arbiter FSM
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_state <= W_IDLE;
            r_wr_owner <= 2'b00;
            r_wr_last  <= 1'b1;
        end else begin
            case (r_wr_state)
                W_IDLE: if (s0.awvalid | s1.awvalid) begin
                    r_wr_owner <= w_wr_gnt1 ? 2'b10 : 2'b01;
                    r_wr_last  <= w_wr_gnt1;
                    r_wr_state <= W_ADDR;
                end
                W_ADDR: if (m.awvalid & m.awready) r_wr_state <= W_DATA;
                W_DATA: if (m.wvalid & m.wready & m.wlast) r_wr_state <= W_RESP;
                W_RESP: if (m.bvalid & m.bready) begin
                    r_wr_state <= W_IDLE;
                    r_wr_owner <= 2'b00;
                end
                default: begin
                    r_wr_state <= W_IDLE;
                    r_wr_owner <= 2'b00;
                end
            endcase
        end
    end

    assign o_rd_owner = r_rd_owner;
    assign o_wr_owner = r_wr_owner;

    // Payloads follow the registered owner; with no owner they follow port 0.
    assign m.arid    = w_rd_sel ? s1.arid    : s0.arid;
    assign m.araddr  = w_rd_sel ? s1.araddr  : s0.araddr;
    assign m.arlen   = w_rd_sel ? s1.arlen   : s0.arlen;
    assign m.arsize  = w_rd_sel ? s1.arsize  : s0.arsize;
    assign m.arburst = w_rd_sel ? s1.arburst : s0.arburst;
    assign m.arlock  = w_rd_sel ? s1.arlock  : s0.arlock;
    assign m.arcache = w_rd_sel ? s1.arcache : s0.arcache;
    assign m.arprot  = w_rd_sel ? s1.arprot  : s0.arprot;
    assign m.arvalid = w_rd_addr & (w_rd_sel ? s1.arvalid : s0.arvalid);
    assign s0.arready = w_rd_addr & r_rd_owner[0] & m.arready;
    assign s1.arready = w_rd_addr & r_rd_owner[1] & m.arready;

    assign s0.rid   = m.rid;
    assign s0.rdata = m.rdata;
    assign s0.rresp = m.rresp;
    assign s0.rlast = m.rlast;
    assign s1.rid   = m.rid;
    assign s1.rdata = m.rdata;
    assign s1.rresp = m.rresp;
    assign s1.rlast = m.rlast;
    assign s0.rvalid = w_rd_data & r_rd_owner[0] & m.rvalid;
    assign s1.rvalid = w_rd_data & r_rd_owner[1] & m.rvalid;
    assign m.rready  = w_rd_data & (w_rd_sel ? s1.rready : s0.rready);

    assign m.awid    = w_wr_sel ? s1.awid    : s0.awid;
    assign m.awaddr  = w_wr_sel ? s1.awaddr  : s0.awaddr;
    assign m.awlen   = w_wr_sel ? s1.awlen   : s0.awlen;
    assign m.awsize  = w_wr_sel ? s1.awsize  : s0.awsize;
    assign m.awburst = w_wr_sel ? s1.awburst : s0.awburst;
    assign m.awlock  = w_wr_sel ? s1.awlock  : s0.awlock;
    assign m.awcache = w_wr_sel ? s1.awcache : s0.awcache;
    assign m.awprot  = w_wr_sel ? s1.awprot  : s0.awprot;
    assign m.awvalid = w_wr_addr & (w_wr_sel ? s1.awvalid : s0.awvalid);
    assign s0.awready = w_wr_addr & r_wr_owner[0] & m.awready;
    assign s1.awready = w_wr_addr & r_wr_owner[1] & m.awready;

    // Early write data from a master stalls here until its AW has been accepted.
    assign m.wid    = w_wr_sel ? s1.wid   : s0.wid;
    assign m.wdata  = w_wr_sel ? s1.wdata : s0.wdata;
    assign m.wstrb  = w_wr_sel ? s1.wstrb : s0.wstrb;
    assign m.wlast  = w_wr_sel ? s1.wlast : s0.wlast;
    assign m.wvalid = w_wr_data & (w_wr_sel ? s1.wvalid : s0.wvalid);
    assign s0.wready = w_wr_data & r_wr_owner[0] & m.wready;
    assign s1.wready = w_wr_data & r_wr_owner[1] & m.wready;

    assign s0.bid   = m.bid;
    assign s0.bresp = m.bresp;
    assign s1.bid   = m.bid;
    assign s1.bresp = m.bresp;
    assign s0.bvalid = w_wr_resp & r_wr_owner[0] & m.bvalid;
    assign s1.bvalid = w_wr_resp & r_wr_owner[1] & m.bvalid;
    assign m.bready  = w_wr_resp & (w_wr_sel ? s1.bready : s0.bready);
endmodule

// File: tb/tb_axi3_rw_arbiter.sv
// Directed self-checking bench for axi3_rw_arbiter: one task per scenario, inline checks.
module tb_axi3_rw_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] rd_owner;
    logic [1:0] wr_owner;
    int         n_chk  = 0;
    int         n_fail = 0;

    axi3_rw_arbiter_if s0_if ();
    axi3_rw_arbiter_if s1_if ();
    axi3_rw_arbiter_if m_if ();

    axi3_rw_arbiter dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .s0         (s0_if),
        .s1         (s1_if),
        .m          (m_if),
        .o_rd_owner (rd_owner),
        .o_wr_owner (wr_owner)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs();
        s0_if.arid = 4'h0; s0_if.araddr = 32'h0; s0_if.arlen = 4'h0; s0_if.arsize = 3'd2;
        s0_if.arburst = 2'b01; s0_if.arlock = 2'b00; s0_if.arcache = 4'h0; s0_if.arprot = 3'd0;
        s0_if.arvalid = 1'b0; s0_if.rready = 1'b0;
        s0_if.awid = 4'h0; s0_if.awaddr = 32'h0; s0_if.awlen = 4'h0; s0_if.awsize = 3'd2;
        s0_if.awburst = 2'b01; s0_if.awlock = 2'b00; s0_if.awcache = 4'h0; s0_if.awprot = 3'd0;
        s0_if.awvalid = 1'b0; s0_if.wid = 4'h0; s0_if.wdata = 32'h0; s0_if.wstrb = 4'h0;
        s0_if.wlast = 1'b0; s0_if.wvalid = 1'b0; s0_if.bready = 1'b0;
        s1_if.arid = 4'h0; s1_if.araddr = 32'h0; s1_if.arlen = 4'h0; s1_if.arsize = 3'd2;
        s1_if.arburst = 2'b01; s1_if.arlock = 2'b00; s1_if.arcache = 4'h0; s1_if.arprot = 3'd0;
        s1_if.arvalid = 1'b0; s1_if.rready = 1'b0;
        s1_if.awid = 4'h0; s1_if.awaddr = 32'h0; s1_if.awlen = 4'h0; s1_if.awsize = 3'd2;
        s1_if.awburst = 2'b01; s1_if.awlock = 2'b00; s1_if.awcache = 4'h0; s1_if.awprot = 3'd0;
        s1_if.awvalid = 1'b0; s1_if.wid = 4'h0; s1_if.wdata = 32'h0; s1_if.wstrb = 4'h0;
        s1_if.wlast = 1'b0; s1_if.wvalid = 1'b0; s1_if.bready = 1'b0;
        m_if.arready = 1'b0; m_if.rid = 4'h0; m_if.rdata = 32'h0; m_if.rresp = 2'b00;
        m_if.rlast = 1'b0; m_if.rvalid = 1'b0; m_if.awready = 1'b0; m_if.wready = 1'b0;
        m_if.bid = 4'h0; m_if.bresp = 2'b00; m_if.bvalid = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        init_inputs();
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        init_inputs();
        s0_if.arvalid = 1'b1; s1_if.awvalid = 1'b1; s0_if.rready = 1'b1; s0_if.bready = 1'b1;
        s0_if.araddr = 32'h0000_1234;
        m_if.arready = 1'b1; m_if.rvalid = 1'b1; m_if.wready = 1'b1; m_if.bvalid = 1'b1;
        repeat (2) cyc();
        n_chk++; if (rd_owner !== 2'b00) begin n_fail++; $display("FAIL reset_rd_owner: got %b exp 00", rd_owner); end
        n_chk++; if (wr_owner !== 2'b00) begin n_fail++; $display("FAIL reset_wr_owner: got %b exp 00", wr_owner); end
        n_chk++; if ({m_if.arvalid, m_if.awvalid, m_if.wvalid} !== 3'b000) begin n_fail++; $display("FAIL reset_m_valids: got %b exp 000", {m_if.arvalid, m_if.awvalid, m_if.wvalid}); end
        n_chk++; if ({m_if.rready, m_if.bready} !== 2'b00) begin n_fail++; $display("FAIL reset_m_readies: got %b exp 00", {m_if.rready, m_if.bready}); end
        n_chk++; if ({s0_if.arready, s1_if.awready, s0_if.wready} !== 3'b000) begin n_fail++; $display("FAIL reset_s_readies: got %b exp 000", {s0_if.arready, s1_if.awready, s0_if.wready}); end
        n_chk++; if ({s0_if.rvalid, s0_if.bvalid, s1_if.bvalid} !== 3'b000) begin n_fail++; $display("FAIL reset_s_valids: got %b exp 000", {s0_if.rvalid, s0_if.bvalid, s1_if.bvalid}); end
        n_chk++; if (m_if.araddr !== 32'h0000_1234) begin n_fail++; $display("FAIL idle_payload_port0: got %h exp 00001234", m_if.araddr); end
        init_inputs();
        rst = 1'b0;
        cyc();
        n_chk++; if (rd_owner !== 2'b00) begin n_fail++; $display("FAIL idle_no_req_owner: got %b exp 00", rd_owner); end
    endtask

    task automatic test_single_read();
        apply_reset();
        s0_if.arid = 4'h5; s0_if.araddr = 32'h1FC0_0000; s0_if.arlen = 4'd3; s0_if.arvalid = 1'b1;
        #1;
        n_chk++; if (m_if.arvalid !== 1'b0) begin n_fail++; $display("FAIL rd_no_comb_grant: got %b exp 0", m_if.arvalid); end
        cyc();
        n_chk++; if (rd_owner !== 2'b01) begin n_fail++; $display("FAIL rd_owner_grant: got %b exp 01", rd_owner); end
        n_chk++; if ({m_if.arvalid, m_if.araddr, m_if.arlen, m_if.arid} !== {1'b1, 32'h1FC0_0000, 4'd3, 4'h5}) begin
            n_fail++; $display("FAIL rd_ar_route: got %b %h %h %h exp 1 1fc00000 3 5", m_if.arvalid, m_if.araddr, m_if.arlen, m_if.arid); end
        m_if.arready = 1'b1;
        #1;
        n_chk++; if ({s0_if.arready, s1_if.arready} !== 2'b10) begin n_fail++; $display("FAIL rd_arready_route: got %b exp 10", {s0_if.arready, s1_if.arready}); end
        cyc();
        s0_if.arvalid = 1'b0; m_if.arready = 1'b0; s0_if.rready = 1'b1; m_if.rid = 4'h5;
        for (int k = 0; k < 4; k++) begin
            m_if.rvalid = 1'b1; m_if.rdata = 32'h0000_00A0 + 32'(k); m_if.rlast = (k == 3);
            #1;
            n_chk++; if ({s0_if.rvalid, s1_if.rvalid, m_if.rready} !== 3'b101) begin n_fail++; $display("FAIL rd_beat_valid[%0d]: got %b exp 101", k, {s0_if.rvalid, s1_if.rvalid, m_if.rready}); end
            n_chk++; if (s0_if.rdata !== 32'h0000_00A0 + 32'(k)) begin n_fail++; $display("FAIL rd_beat_data[%0d]: got %h exp %h", k, s0_if.rdata, 32'h0000_00A0 + 32'(k)); end
            n_chk++; if (s0_if.rlast !== (k == 3)) begin n_fail++; $display("FAIL rd_beat_last[%0d]: got %b exp %b", k, s0_if.rlast, (k == 3)); end
            cyc();
        end
        m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
        #1;
        n_chk++; if ({rd_owner, m_if.rready} !== 3'b000) begin n_fail++; $display("FAIL rd_done_idle: got %b exp 000", {rd_owner, m_if.rready}); end
    endtask

    task automatic test_read_contention();
        apply_reset();
        s0_if.arid = 4'h3; s0_if.araddr = 32'h0000_1000; s1_if.arid = 4'hA; s1_if.araddr = 32'h0000_2000;
        s0_if.arvalid = 1'b1; s1_if.arvalid = 1'b1;
        cyc();
        n_chk++; if ({rd_owner, m_if.arid} !== {2'b01, 4'h3}) begin n_fail++; $display("FAIL cont_first_s0: got %b %h exp 01 3", rd_owner, m_if.arid); end
        m_if.arready = 1'b1;
        #1;
        n_chk++; if ({s0_if.arready, s1_if.arready} !== 2'b10) begin n_fail++; $display("FAIL cont_arready_s0: got %b exp 10", {s0_if.arready, s1_if.arready}); end
        cyc();
        s0_if.arvalid = 1'b0; m_if.arready = 1'b0;
        m_if.rvalid = 1'b1; m_if.rlast = 1'b1; s0_if.rready = 1'b1;
        #1;
        n_chk++; if ({s0_if.rvalid, s1_if.rvalid} !== 2'b10) begin n_fail++; $display("FAIL cont_rvalid_s0: got %b exp 10", {s0_if.rvalid, s1_if.rvalid}); end
        cyc();
        m_if.rvalid = 1'b0; m_if.rlast = 1'b0; s0_if.rready = 1'b0;
        #1;
        n_chk++; if ({rd_owner, m_if.arvalid} !== 3'b000) begin n_fail++; $display("FAIL cont_idle_gap: got %b exp 000", {rd_owner, m_if.arvalid}); end
        cyc();
        n_chk++; if ({rd_owner, m_if.arvalid, m_if.arid, m_if.araddr} !== {2'b10, 1'b1, 4'hA, 32'h0000_2000}) begin
            n_fail++; $display("FAIL cont_second_s1: got %b %b %h %h exp 10 1 a 00002000", rd_owner, m_if.arvalid, m_if.arid, m_if.araddr); end
        m_if.arready = 1'b1;
        cyc();
        s1_if.arvalid = 1'b0; m_if.arready = 1'b0;
        m_if.rvalid = 1'b1; m_if.rlast = 1'b1; s1_if.rready = 1'b1;
        #1;
        n_chk++; if ({s0_if.rvalid, s1_if.rvalid} !== 2'b01) begin n_fail++; $display("FAIL cont_rvalid_s1: got %b exp 01", {s0_if.rvalid, s1_if.rvalid}); end
        cyc();
        m_if.rvalid = 1'b0; m_if.rlast = 1'b0; s1_if.rready = 1'b0;
        s0_if.arvalid = 1'b1; s1_if.arvalid = 1'b1;
        cyc();
        n_chk++; if (rd_owner !== 2'b01) begin n_fail++; $display("FAIL cont_third_s0: got %b exp 01", rd_owner); end
    endtask

    task automatic test_concurrent_rw();
        apply_reset();
        s1_if.arid = 4'h2; s1_if.arlen = 4'd7; s1_if.arvalid = 1'b1;
        s0_if.awid = 4'h6; s0_if.awaddr = 32'h0000_1000; s0_if.awlen = 4'd0; s0_if.awvalid = 1'b1;
        s0_if.wid = 4'h6; s0_if.wdata = 32'hDEAD_BEEF; s0_if.wstrb = 4'hF; s0_if.wlast = 1'b1; s0_if.wvalid = 1'b1;
        cyc();
        n_chk++; if ({rd_owner, wr_owner} !== 4'b1001) begin n_fail++; $display("FAIL crw_owners: got %b exp 1001", {rd_owner, wr_owner}); end
        n_chk++; if ({m_if.arlen, m_if.awaddr} !== {4'd7, 32'h0000_1000}) begin n_fail++; $display("FAIL crw_addr_route: got %h %h exp 7 00001000", m_if.arlen, m_if.awaddr); end
        m_if.arready = 1'b1; m_if.awready = 1'b1;
        #1;
        n_chk++; if ({s1_if.arready, s0_if.awready, s0_if.wready} !== 3'b110) begin n_fail++; $display("FAIL crw_addr_ready: got %b exp 110", {s1_if.arready, s0_if.awready, s0_if.wready}); end
        cyc();
        s1_if.arvalid = 1'b0; s0_if.awvalid = 1'b0; m_if.arready = 1'b0; m_if.awready = 1'b0;
        m_if.wready = 1'b1; s1_if.rready = 1'b1; s0_if.bready = 1'b1;
        m_if.rid = 4'h2; m_if.bid = 4'h6; m_if.bresp = 2'b01;
        for (int k = 0; k < 8; k++) begin
            m_if.rvalid = 1'b1; m_if.rdata = 32'h0000_0100 + 32'(k); m_if.rlast = (k == 7); m_if.bvalid = (k == 1);
            #1;
            n_chk++; if ({s1_if.rvalid, s0_if.rvalid, s1_if.rdata} !== {2'b10, 32'h0000_0100 + 32'(k)}) begin
                n_fail++; $display("FAIL crw_rd_beat[%0d]: got %b%b %h exp 10 %h", k, s1_if.rvalid, s0_if.rvalid, s1_if.rdata, 32'h0000_0100 + 32'(k)); end
            if (k == 0) begin
                n_chk++; if ({m_if.wvalid, m_if.wdata, m_if.wstrb, s0_if.wready, s1_if.wready} !== {1'b1, 32'hDEAD_BEEF, 4'hF, 2'b10}) begin
                    n_fail++; $display("FAIL crw_w_route: got %b %h %h %b%b exp 1 deadbeef f 10", m_if.wvalid, m_if.wdata, m_if.wstrb, s0_if.wready, s1_if.wready); end
            end
            if (k == 1) begin
                n_chk++; if ({s0_if.bvalid, s1_if.bvalid, s0_if.bresp, s0_if.bid, m_if.bready} !== {2'b10, 2'b01, 4'h6, 1'b1}) begin
                    n_fail++; $display("FAIL crw_b_route: got %b%b %b %h %b exp 10 01 6 1", s0_if.bvalid, s1_if.bvalid, s0_if.bresp, s0_if.bid, m_if.bready); end
            end
            cyc();
            if (k == 0) begin
                s0_if.wvalid = 1'b0; m_if.wready = 1'b0;
            end
        end
        m_if.rvalid = 1'b0; m_if.rlast = 1'b0; m_if.bvalid = 1'b0;
        #1;
        n_chk++; if ({rd_owner, wr_owner} !== 4'b0000) begin n_fail++; $display("FAIL crw_both_done: got %b exp 0000", {rd_owner, wr_owner}); end
    endtask

    task automatic test_early_w();
        apply_reset();
        s0_if.awvalid = 1'b1; s0_if.awaddr = 32'h0000_4000;
        s0_if.wvalid = 1'b1; s0_if.wdata = 32'h1234_5678; s0_if.wstrb = 4'h3; s0_if.wlast = 1'b1;
        m_if.wready = 1'b1;
        cyc();
        for (int c = 0; c < 3; c++) begin
            n_chk++; if ({m_if.awvalid, s0_if.wready, m_if.wvalid, s0_if.awready} !== 4'b1000) begin
                n_fail++; $display("FAIL earlyw_stall[%0d]: got %b exp 1000", c, {m_if.awvalid, s0_if.wready, m_if.wvalid, s0_if.awready}); end
            cyc();
        end
        m_if.awready = 1'b1;
        #1;
        n_chk++; if ({s0_if.awready, s0_if.wready} !== 2'b10) begin n_fail++; $display("FAIL earlyw_aw_hs: got %b exp 10", {s0_if.awready, s0_if.wready}); end
        cyc();
        s0_if.awvalid = 1'b0; m_if.awready = 1'b0;
        n_chk++; if ({s0_if.wready, m_if.wvalid, m_if.wdata} !== {2'b11, 32'h1234_5678}) begin
            n_fail++; $display("FAIL earlyw_data: got %b%b %h exp 11 12345678", s0_if.wready, m_if.wvalid, m_if.wdata); end
        cyc();
        s0_if.wvalid = 1'b0; m_if.wready = 1'b0;
        #1;
        n_chk++; if ({m_if.wvalid, wr_owner} !== 3'b001) begin n_fail++; $display("FAIL earlyw_wlast_exit: got %b exp 001", {m_if.wvalid, wr_owner}); end
        m_if.bvalid = 1'b1; s0_if.bready = 1'b1;
        #1;
        n_chk++; if ({s0_if.bvalid, m_if.bready} !== 2'b11) begin n_fail++; $display("FAIL earlyw_b: got %b exp 11", {s0_if.bvalid, m_if.bready}); end
        cyc();
        m_if.bvalid = 1'b0;
        n_chk++; if (wr_owner !== 2'b00) begin n_fail++; $display("FAIL earlyw_done: got %b exp 00", wr_owner); end
    endtask

    task automatic test_backpressure();
        logic [31:0] pv;
        logic [31:0] pr;
        logic        rv;
        logic        rr;
        logic        hold;
        int          idx;
        apply_reset();
        s0_if.arlen = 4'd15; s0_if.arvalid = 1'b1;
        cyc();
        m_if.arready = 1'b1;
        cyc();
        s0_if.arvalid = 1'b0; m_if.arready = 1'b0;
        pv = 32'hB5A3_6E9D; pr = 32'h6DB7_5AEF; hold = 1'b0; idx = 0;
        for (int c = 0; c < 200 && idx < 16; c++) begin
            rv = hold | pv[c % 32];
            rr = pr[c % 32];
            m_if.rvalid = rv; m_if.rdata = 32'hC000_0000 + 32'(idx); m_if.rlast = (idx == 15); s0_if.rready = rr;
            #1;
            n_chk++; if ({s0_if.rvalid, m_if.rready} !== {rv, rr}) begin n_fail++; $display("FAIL bp_pass[%0d]: got %b exp %b", c, {s0_if.rvalid, m_if.rready}, {rv, rr}); end
            if (rv && rr) begin
                n_chk++; if (s0_if.rdata !== 32'hC000_0000 + 32'(idx)) begin n_fail++; $display("FAIL bp_order[%0d]: got %h exp %h", idx, s0_if.rdata, 32'hC000_0000 + 32'(idx)); end
                idx++;
            end
            hold = rv & ~rr;
            cyc();
        end
        m_if.rvalid = 1'b0; m_if.rlast = 1'b0; s0_if.rready = 1'b0;
        #1;
        n_chk++; if (idx != 16) begin n_fail++; $display("FAIL bp_timeout: got %0d beats exp 16", idx); end
        n_chk++; if (rd_owner !== 2'b00) begin n_fail++; $display("FAIL bp_done: got %b exp 00", rd_owner); end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        s0_if.arlen = 4'd3; s0_if.arvalid = 1'b1;
        cyc();
        m_if.arready = 1'b1;
        cyc();
        s0_if.arvalid = 1'b0; m_if.arready = 1'b0; s0_if.rready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_if.rvalid = 1'b1; m_if.rdata = 32'h0000_00A0 + 32'(k);
            cyc();
        end
        m_if.rdata = 32'h0000_00A2;
        #1;
        n_chk++; if (s0_if.rvalid !== 1'b1) begin n_fail++; $display("FAIL rstmid_beat2: got %b exp 1", s0_if.rvalid); end
        rst = 1'b1;
        #1;
        n_chk++; if ({s0_if.rvalid, m_if.rready, m_if.arvalid, rd_owner} !== 5'b00000) begin
            n_fail++; $display("FAIL rstmid_async: got %b exp 00000", {s0_if.rvalid, m_if.rready, m_if.arvalid, rd_owner}); end
        init_inputs();
        cyc();
        rst = 1'b0;
        s0_if.arvalid = 1'b1; s1_if.arvalid = 1'b1;
        cyc();
        n_chk++; if ({rd_owner, m_if.arvalid} !== 3'b011) begin n_fail++; $display("FAIL rstmid_rearb: got %b exp 011", {rd_owner, m_if.arvalid}); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        init_inputs();
        test_reset();
        test_single_read();
        test_read_contention();
        test_concurrent_rw();
        test_early_w();
        test_backpressure();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
